// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array front end: buffer command
// encodings and the loader FSM state type.
package systolic_pkg;

  localparam logic [1:0] BUF_NOP    = 2'b00;
  localparam logic [1:0] BUF_STORE  = 2'b01;
  localparam logic [1:0] BUF_STREAM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOAD   = 2'b01,
    ST_STREAM = 2'b10,
    ST_FINISH = 2'b11
  } loader_state_e;

endpackage

// File: rtl/buffer_loader.sv
// Loads up to ARR_SIZE/2 32-bit words into a banked buffer, then streams
// every bank address once and pulses done.
module buffer_loader
  import systolic_pkg::*;
#(
  parameter int unsigned ARR_SIZE = 4,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [$clog2(ARR_SIZE/2+1)-1:0]      num_words,
  input  logic                                 abort,
  input  logic                                 in_valid,
  input  logic [31:0]                          in_data,
  output logic                                 in_ready,
  output logic [31:0]                          buf_data,
  output logic [ADDR_W-1:0]                    buf_addr,
  output logic [1:0]                           buf_state,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned HALF = ARR_SIZE / 2;
  localparam int unsigned NW_W = $clog2(ARR_SIZE/2+1);
  localparam int unsigned J_W  = (ARR_SIZE > 2) ? $clog2(ARR_SIZE) : 1;

  loader_state_e   state;
  logic [NW_W-1:0] target;
  logic [NW_W-1:0] k;
  logic [J_W-1:0]  j;
  logic [NW_W-1:0] nw_clamped;
  logic            handshake;

  always_comb begin
    nw_clamped = (num_words > NW_W'(HALF)) ? NW_W'(HALF) : num_words;
  end

  assign in_ready  = (state == ST_LOAD) && (k < target);
  assign handshake = in_valid && in_ready;

  // Outputs default to NOP each cycle; each state overrides what it drives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      target    <= '0;
      k         <= '0;
      j         <= '0;
      buf_state <= BUF_NOP;
      buf_addr  <= '0;
      buf_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      buf_state <= BUF_NOP;
      buf_addr  <= '0;
      buf_data  <= '0;
      done      <= 1'b0;
      if (abort) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              target <= nw_clamped;
              k      <= '0;
              busy   <= 1'b1;
              state  <= (nw_clamped == '0) ? ST_FINISH : ST_LOAD;
            end
          end
          ST_LOAD: begin
            if (handshake) begin
              buf_state <= BUF_STORE;
              buf_addr  <= ADDR_W'(k) << 1;
              buf_data  <= in_data;
              k         <= k + NW_W'(1);
              if (k == target - NW_W'(1)) begin
                state <= ST_STREAM;
                j     <= '0;
              end
            end
          end
          ST_STREAM: begin
            buf_state <= BUF_STREAM;
            buf_addr  <= ADDR_W'(j);
            if (j == J_W'(ARR_SIZE - 1)) begin
              state <= ST_FINISH;
            end else begin
              j <= j + J_W'(1);
            end
          end
          ST_FINISH: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_buffer_loader.sv
// Directed, table-driven bench for buffer_loader (ARR_SIZE=4, ADDR_W=7).
module tb_buffer_loader;

  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] S = 2'b01;
  localparam logic [1:0] T = 2'b10;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  num_words;
  logic        abort;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic [31:0] buf_data;
  logic [6:0]  buf_addr;
  logic [1:0]  buf_state;
  logic        busy;
  logic        done;

  buffer_loader #(.ARR_SIZE(4), .ADDR_W(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .buf_data  (buf_data),
    .buf_addr  (buf_addr),
    .buf_state (buf_state),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per clock: inputs driven before the edge, in_ready expected
  // before the edge, registered outputs expected just after it.
  typedef struct {
    logic        start;
    logic [1:0]  nw;
    logic        abort;
    logic        iv;
    logic [31:0] din;
    logic        ready;
    logic [1:0]  st;
    logic [6:0]  addr;
    logic [31:0] dat;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  function automatic void add(input logic s, input logic [1:0] nw, input logic ab,
                              input logic iv, input logic [31:0] din, input logic rdy,
                              input logic [1:0] st, input logic [6:0] addr,
                              input logic [31:0] dat, input logic bsy, input logic dn);
    vec_t v;
    v.start = s;  v.nw = nw;   v.abort = ab;  v.iv = iv;    v.din = din;
    v.ready = rdy; v.st = st;  v.addr = addr; v.dat = dat;  v.busy = bsy; v.done = dn;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    start = v.start; num_words = v.nw; abort = v.abort;
    in_valid = v.iv; in_data = v.din;
    #1 check({tag, " in_ready"}, 64'(in_ready), 64'(v.ready));
    @(posedge clk);
    #1 check({tag, " outputs {state,addr,data,busy,done}"},
             64'({buf_state, buf_addr, buf_data, busy, done}),
             64'({v.st, v.addr, v.dat, v.busy, v.done}));
  endtask

  task automatic run_vecs(input string phase);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("%s vec%0d", phase, i));
    vecs.delete();
  endtask

  task automatic check_zero(input string name);
    check({name, " outputs"}, 64'({buf_state, buf_addr, buf_data, busy, done}), 64'(0));
    check({name, " in_ready"}, 64'(in_ready), 64'(0));
  endtask

  initial begin
    vec_t hv;
    rst = 1'b0; start = 1'b0; num_words = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0;
    #12 check_zero("reset");
    @(negedge clk) rst = 1'b1;

    // Two words, in_valid high: STORE 0, STORE 2, STREAM 0..3, done.
    add(1, 2, 0, 0, 32'h0,        0, N, 0, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'hBBBBAAAA, 1, S, 0, 32'hBBBBAAAA, 1, 0);
    add(0, 0, 0, 1, 32'hDDDDCCCC, 1, S, 2, 32'hDDDDCCCC, 1, 0);
    add(0, 0, 0, 1, 32'h11111111, 0, T, 0, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'h11111111, 0, T, 1, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'h11111111, 0, T, 2, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'h11111111, 0, T, 3, 32'h0,        1, 0);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 1);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 0);
    // Stalling producer (1,0,0,1); a start while busy is ignored.
    add(1, 2, 0, 0, 32'h0,        0, N, 0, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'h12345678, 1, S, 0, 32'h12345678, 1, 0);
    add(1, 0, 0, 0, 32'h0,        1, N, 0, 32'h0,        1, 0);
    add(0, 0, 0, 0, 32'h0,        1, N, 0, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'h9ABCDEF0, 1, S, 2, 32'h9ABCDEF0, 1, 0);
    for (int a = 0; a < 4; a++) add(0, 0, 0, 0, 32'h0, 0, T, 7'(a), 32'h0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 1);
    // Zero words: straight to FINISH, no STORE/STREAM.
    add(1, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        1, 0);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 1);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 0);
    // num_words=3 clamps to 2; in_ready drops with in_valid still high.
    add(1, 3, 0, 0, 32'h0,        0, N, 0, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'hA5A5A5A5, 1, S, 0, 32'hA5A5A5A5, 1, 0);
    add(0, 0, 0, 1, 32'h5A5A5A5A, 1, S, 2, 32'h5A5A5A5A, 1, 0);
    for (int a = 0; a < 4; a++) add(0, 0, 0, 1, 32'hFFFFFFFF, 0, T, 7'(a), 32'h0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 1);
    // Abort in the second STREAM cycle, then a normal one-word job.
    add(1, 1, 0, 0, 32'h0,        0, N, 0, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'hCAFEF00D, 1, S, 0, 32'hCAFEF00D, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, T, 0, 32'h0,        1, 0);
    add(0, 0, 1, 0, 32'h0,        0, N, 0, 32'h0,        0, 0);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 0);
    add(1, 1, 0, 0, 32'h0,        0, N, 0, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'h0F0F0F0F, 1, S, 0, 32'h0F0F0F0F, 1, 0);
    for (int a = 0; a < 4; a++) add(0, 0, 0, 0, 32'h0, 0, T, 7'(a), 32'h0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 1);
    // Abort beats a same-cycle handshake; start+abort in IDLE does nothing.
    add(1, 2, 0, 0, 32'h0,        0, N, 0, 32'h0,        1, 0);
    add(0, 0, 1, 1, 32'hDEADBEEF, 1, N, 0, 32'h0,        0, 0);
    add(1, 2, 1, 0, 32'h0,        0, N, 0, 32'h0,        0, 0);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 0);
    run_vecs("main");

    // Asynchronous reset between edges in the middle of LOAD.
    hv = '{start:1, nw:2, abort:0, iv:0, din:32'h0, ready:0, st:N, addr:0, dat:32'h0, busy:1, done:0};
    apply(hv, "pre-reset start");
    hv = '{start:0, nw:0, abort:0, iv:1, din:32'h55556666, ready:1, st:S, addr:0, dat:32'h55556666, busy:1, done:0};
    apply(hv, "pre-reset store");
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 32'h77776666;
    #2 rst = 1'b0;
    #1 check_zero("async reset");
    @(posedge clk);
    #1 check_zero("reset held");
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_data = '0;

    add(1, 1, 0, 0, 32'h0,        0, N, 0, 32'h0,        1, 0);
    add(0, 0, 0, 1, 32'h77778888, 1, S, 0, 32'h77778888, 1, 0);
    for (int a = 0; a < 4; a++) add(0, 0, 0, 0, 32'h0, 0, T, 7'(a), 32'h0, 1, 0);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 1);
    add(0, 0, 0, 0, 32'h0,        0, N, 0, 32'h0,        0, 0);
    run_vecs("post-reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
